// File: rtl/trap_pkg.sv
// Shared types and constants for the trap sequencer: FSM states, interrupt
// cause codes, the mtvec mode encoding, and trap target helpers.
package trap_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DRAIN    = 2'd1,
    REDIRECT = 2'd2,
    SLEEP    = 2'd3
  } state_t;

  localparam logic [3:0] CAUSE_MSI = 4'd3;
  localparam logic [3:0] CAUSE_MTI = 4'd7;
  localparam logic [3:0] CAUSE_MEI = 4'd11;

  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

  function automatic logic [31:0] trap_base(input logic [31:0] mtvec);
    return {mtvec[31:2], 2'b00};
  endfunction

  // Vectored interrupt entry: base + 4*cause.
  function automatic logic [31:0] vector_target(input logic [31:0] mtvec, input logic [3:0] cause);
    return trap_base(mtvec) + {26'd0, cause, 2'b00};
  endfunction

endpackage

// File: rtl/trap_sequencer_if.sv
// Bundle of writeback, interrupt, CSR and fetch/hazard signals seen by the
// trap sequencer; slave is the sequencer side, master the core side.
interface trap_sequencer_if;
  logic        valid_in;
  logic        exception_in;
  logic [3:0]  ecause_in;
  logic [31:0] pc_in;
  logic [31:0] next_pc_in;
  logic        mret_in;
  logic        wfi_in;
  logic        msip;
  logic        mtip;
  logic        meip;
  logic        mie_global;
  logic [2:0]  mie_mask;
  logic [31:0] mtvec_in;
  logic [31:0] mepc_in;

  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap_commit;
  logic        mret_commit;
  logic [3:0]  trap_cause;
  logic        trap_interrupt;
  logic [31:0] trap_epc;
  logic        sleeping;

  modport slave (
    input  valid_in, exception_in, ecause_in, pc_in, next_pc_in, mret_in, wfi_in,
           msip, mtip, meip, mie_global, mie_mask, mtvec_in, mepc_in,
    output flush, redirect_valid, redirect_pc, trap_commit, mret_commit,
           trap_cause, trap_interrupt, trap_epc, sleeping
  );

  modport master (
    output valid_in, exception_in, ecause_in, pc_in, next_pc_in, mret_in, wfi_in,
           msip, mtip, meip, mie_global, mie_mask, mtvec_in, mepc_in,
    input  flush, redirect_valid, redirect_pc, trap_commit, mret_commit,
           trap_cause, trap_interrupt, trap_epc, sleeping
  );
endinterface

// File: rtl/trap_sequencer_irq_priority.sv
// Combinational interrupt resolver: masks pending lines, reports wake/irq and
// picks the highest-priority cause (MEI > MTI > MSI).
module irq_priority
  import trap_pkg::*;
(
  input  logic [2:0] pending,
  input  logic [2:0] mask,
  input  logic       global_en,
  output logic       irq,
  output logic       wake,
  output logic [3:0] cause
);

  logic [2:0] pend;

  assign pend = pending & mask;
  assign wake = |pend;
  assign irq  = wake & global_en;

  always_comb begin
    cause = 4'd0;
    if (pend[2]) begin
      cause = CAUSE_MEI;
    end else if (pend[1]) begin
      cause = CAUSE_MTI;
    end else if (pend[0]) begin
      cause = CAUSE_MSI;
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Trap entry / mret / WFI sequencer beside writeback: flush, drain, commit CSR
// strobes and issue one fetch redirect. TRAP_VECTORED_EN enables vectored irq entry.
module trap_sequencer
  import trap_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  trap_sequencer_if.slave  bus
);

  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [31:0]         target_reg, target_next;
  logic [31:0]         resume_reg, resume_next;
  logic                redirect_valid_reg;
  logic [31:0]         redirect_pc_reg;

  logic                irq, wake;
  logic [3:0]          irq_cause;
  logic [31:0]         irq_target;
  logic [31:0]         base;

  logic                flush_c, trap_commit_c, mret_commit_c, intr_c;
  logic [3:0]          cause_c;
  logic [31:0]         epc_c;

  irq_priority u_irq_priority (
    .pending   ({bus.meip, bus.mtip, bus.msip}),
    .mask      (bus.mie_mask),
    .global_en (bus.mie_global),
    .irq       (irq),
    .wake      (wake),
    .cause     (irq_cause)
  );

  assign base = trap_base(bus.mtvec_in);

`ifdef TRAP_VECTORED_EN
  assign irq_target = (bus.mtvec_in[1:0] == MTVEC_MODE_VECTORED) ?
                      vector_target(bus.mtvec_in, irq_cause) : base;
`else
  assign irq_target = base;
`endif

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    target_next   = target_reg;
    resume_next   = resume_reg;
    flush_c       = 1'b0;
    trap_commit_c = 1'b0;
    mret_commit_c = 1'b0;
    intr_c        = 1'b0;
    cause_c       = 4'd0;
    epc_c         = 32'd0;

    case (state_reg)
      RUN: begin
        if (bus.valid_in) begin
          if (irq) begin
            trap_commit_c = 1'b1;
            intr_c        = 1'b1;
            cause_c       = irq_cause;
            epc_c         = bus.pc_in;
            target_next   = irq_target;
          end else if (bus.exception_in) begin
            trap_commit_c = 1'b1;
            cause_c       = bus.ecause_in;
            epc_c         = bus.pc_in;
            target_next   = base;
          end else if (bus.mret_in) begin
            mret_commit_c = 1'b1;
            target_next   = bus.mepc_in;
          end else if (bus.wfi_in && !wake) begin
            flush_c     = 1'b1;
            resume_next = bus.next_pc_in;
            state_next  = SLEEP;
          end
          if (trap_commit_c || mret_commit_c) begin
            flush_c    = 1'b1;
            cnt_next   = CNT_W'(FLUSH_CYCLES);
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        flush_c  = 1'b1;
        cnt_next = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) begin
          state_next = REDIRECT;
        end
      end
      REDIRECT: begin
        state_next = RUN;
      end
      SLEEP: begin
        flush_c = 1'b1;
        if (wake) begin
          if (irq) begin
            trap_commit_c = 1'b1;
            intr_c        = 1'b1;
            cause_c       = irq_cause;
            epc_c         = resume_reg;
            target_next   = irq_target;
          end else begin
            target_next = resume_reg;
          end
          cnt_next   = CNT_W'(FLUSH_CYCLES);
          state_next = DRAIN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg          <= RUN;
      cnt_reg            <= '0;
      target_reg         <= '0;
      resume_reg         <= '0;
      redirect_valid_reg <= 1'b0;
      redirect_pc_reg    <= '0;
    end else begin
      state_reg          <= state_next;
      cnt_reg            <= cnt_next;
      target_reg         <= target_next;
      resume_reg         <= resume_next;
      redirect_valid_reg <= (state_next == REDIRECT);
      if (state_next == REDIRECT) begin
        redirect_pc_reg <= target_reg;
      end
    end
  end

  // Mealy outputs are gated so that every output is low while reset is held.
  assign bus.flush          = flush_c & reset_n;
  assign bus.trap_commit    = trap_commit_c & reset_n;
  assign bus.mret_commit    = mret_commit_c & reset_n;
  assign bus.trap_interrupt = intr_c & reset_n;
  assign bus.trap_cause     = reset_n ? cause_c : 4'd0;
  assign bus.trap_epc       = reset_n ? epc_c : 32'd0;
  assign bus.sleeping       = (state_reg == SLEEP);
  assign bus.redirect_valid = redirect_valid_reg;
  assign bus.redirect_pc    = redirect_pc_reg;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: traps, interrupt priority, mret, WFI
// sleep/wake, drain immunity and reset while sleeping.
module tb_trap_sequencer;

  localparam int FC = 2;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  trap_sequencer_if bus();

  trap_sequencer #(.FLUSH_CYCLES(FC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

`ifdef TRAP_VECTORED_EN
  localparam bit VEC = 1'b1;
`else
  localparam bit VEC = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.valid_in     = 1'b0;
    bus.exception_in = 1'b0;
    bus.ecause_in    = 4'd0;
    bus.pc_in        = 32'd0;
    bus.next_pc_in   = 32'd0;
    bus.mret_in      = 1'b0;
    bus.wfi_in       = 1'b0;
    bus.msip         = 1'b0;
    bus.mtip         = 1'b0;
    bus.meip         = 1'b0;
    bus.mie_global   = 1'b0;
    bus.mie_mask     = 3'b000;
  endtask

  // Cycles after the detection cycle: FC flush cycles, then the redirect.
  task automatic drain_and_redirect(input string tag, input logic [31:0] exp_pc, input bit pulse_exc);
    for (int i = 0; i < FC; i++) begin
      @(negedge clk);
      clear_inputs();
      if (pulse_exc && i == 0) begin
        bus.valid_in     = 1'b1;
        bus.exception_in = 1'b1;
        bus.ecause_in    = 4'd5;
        bus.pc_in        = 32'h999;
      end
      #1;
      check({tag, "_drain_flush"}, bus.flush, 1);
      check({tag, "_drain_trap"}, bus.trap_commit, 0);
      check({tag, "_drain_mret"}, bus.mret_commit, 0);
      check({tag, "_drain_rv"}, bus.redirect_valid, 0);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    check({tag, "_redir_flush"}, bus.flush, 0);
    check({tag, "_redir_valid"}, bus.redirect_valid, 1);
    check({tag, "_redir_pc"}, bus.redirect_pc, exp_pc);
    check({tag, "_redir_sleep"}, bus.sleeping, 0);
    $display("txn %s: redirect_pc=0x%08h expected=0x%08h", tag, bus.redirect_pc, exp_pc);
    @(negedge clk);
    #1;
    check({tag, "_after_rv"}, bus.redirect_valid, 0);
    check({tag, "_after_flush"}, bus.flush, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_flush"}, bus.flush, 0);
    check({tag, "_rv"}, bus.redirect_valid, 0);
    check({tag, "_rpc"}, bus.redirect_pc, 0);
    check({tag, "_trap"}, bus.trap_commit, 0);
    check({tag, "_mret"}, bus.mret_commit, 0);
    check({tag, "_cause"}, bus.trap_cause, 0);
    check({tag, "_intr"}, bus.trap_interrupt, 0);
    check({tag, "_epc"}, bus.trap_epc, 0);
    check({tag, "_sleep"}, bus.sleeping, 0);
  endtask

  initial begin
    clear_inputs();
    bus.mtvec_in = 32'd0;
    bus.mepc_in  = 32'd0;
    reset_n = 1'b0;

    // Reset with an active exception on the bus: outputs must still be 0.
    bus.valid_in     = 1'b1;
    bus.exception_in = 1'b1;
    bus.pc_in        = 32'h40;
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    $display("txn reset: outputs checked");
    @(negedge clk);
    clear_inputs();
    reset_n = 1'b1;

    // Enabled interrupt without a valid instruction: nothing happens.
    @(negedge clk);
    bus.meip = 1'b1; bus.mie_mask = 3'b100; bus.mie_global = 1'b1;
    #1;
    check("novalid_flush", bus.flush, 0);
    check("novalid_trap", bus.trap_commit, 0);
    $display("txn novalid_irq: flush=%0b", bus.flush);

    // Illegal instruction.
    @(negedge clk);
    clear_inputs();
    bus.mtvec_in = 32'h800;
    bus.valid_in = 1'b1; bus.exception_in = 1'b1; bus.ecause_in = 4'd2; bus.pc_in = 32'h100;
    #1;
    check("ill_trap", bus.trap_commit, 1);
    check("ill_cause", bus.trap_cause, 2);
    check("ill_intr", bus.trap_interrupt, 0);
    check("ill_epc", bus.trap_epc, 32'h100);
    check("ill_flush", bus.flush, 1);
    check("ill_mret", bus.mret_commit, 0);
    $display("txn illegal: cause=%0d epc=0x%08h", bus.trap_cause, bus.trap_epc);
    drain_and_redirect("ill", 32'h800, 1'b0);

    // Exception pulsed during drain must not cause a second trap.
    @(negedge clk);
    bus.valid_in = 1'b1; bus.exception_in = 1'b1; bus.ecause_in = 4'd13; bus.pc_in = 32'h400;
    #1;
    check("pulse_trap", bus.trap_commit, 1);
    check("pulse_cause", bus.trap_cause, 13);
    $display("txn drain_pulse: cause=%0d", bus.trap_cause);
    drain_and_redirect("pulse", 32'h800, 1'b1);

    // Interrupt beats a same-cycle exception.
    @(negedge clk);
    bus.mtvec_in = 32'h801;
    bus.meip = 1'b1; bus.mie_mask = 3'b100; bus.mie_global = 1'b1;
    bus.valid_in = 1'b1; bus.exception_in = 1'b1; bus.ecause_in = 4'd2; bus.pc_in = 32'h300;
    #1;
    check("irq_trap", bus.trap_commit, 1);
    check("irq_cause", bus.trap_cause, 11);
    check("irq_intr", bus.trap_interrupt, 1);
    check("irq_epc", bus.trap_epc, 32'h300);
    $display("txn irq_vs_exc: cause=%0d intr=%0b", bus.trap_cause, bus.trap_interrupt);
    drain_and_redirect("irq", VEC ? 32'h82C : 32'h800, 1'b0);

    // mret.
    @(negedge clk);
    bus.mepc_in = 32'h2000;
    bus.valid_in = 1'b1; bus.mret_in = 1'b1;
    #1;
    check("mret_commit", bus.mret_commit, 1);
    check("mret_trap", bus.trap_commit, 0);
    check("mret_flush", bus.flush, 1);
    $display("txn mret: mret_commit=%0b", bus.mret_commit);
    drain_and_redirect("mret", 32'h2000, 1'b0);

    // WFI with a masked-in pending line is a nop.
    @(negedge clk);
    bus.valid_in = 1'b1; bus.wfi_in = 1'b1; bus.next_pc_in = 32'h208;
    bus.mtip = 1'b1; bus.mie_mask = 3'b010; bus.mie_global = 1'b0;
    #1;
    check("wfinop_flush", bus.flush, 0);
    check("wfinop_trap", bus.trap_commit, 0);
    @(negedge clk);
    clear_inputs();
    #1;
    check("wfinop_sleep", bus.sleeping, 0);
    $display("txn wfi_nop: sleeping=%0b", bus.sleeping);

    // WFI, then wake with interrupts globally disabled.
    @(negedge clk);
    bus.valid_in = 1'b1; bus.wfi_in = 1'b1; bus.next_pc_in = 32'h204;
    #1;
    check("wfi_flush", bus.flush, 1);
    check("wfi_trap", bus.trap_commit, 0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      clear_inputs();
      #1;
      check("wfi_sleeping", bus.sleeping, 1);
      check("wfi_sleep_flush", bus.flush, 1);
    end
    $display("txn wfi: slept 50 cycles");
    @(negedge clk);
    bus.mtip = 1'b1; bus.mie_mask = 3'b010; bus.mie_global = 1'b0;
    #1;
    check("wake0_trap", bus.trap_commit, 0);
    check("wake0_flush", bus.flush, 1);
    drain_and_redirect("wake0", 32'h204, 1'b0);

    // WFI, then wake with interrupts enabled: trap with epc = resume pc.
    @(negedge clk);
    bus.valid_in = 1'b1; bus.wfi_in = 1'b1; bus.next_pc_in = 32'h204;
    #1;
    repeat (5) @(negedge clk);
    clear_inputs();
    #1;
    check("wfi2_sleeping", bus.sleeping, 1);
    @(negedge clk);
    bus.mtip = 1'b1; bus.mie_mask = 3'b010; bus.mie_global = 1'b1;
    #1;
    check("wake1_trap", bus.trap_commit, 1);
    check("wake1_cause", bus.trap_cause, 7);
    check("wake1_intr", bus.trap_interrupt, 1);
    check("wake1_epc", bus.trap_epc, 32'h204);
    $display("txn wake_irq: cause=%0d epc=0x%08h", bus.trap_cause, bus.trap_epc);
    drain_and_redirect("wake1", VEC ? 32'h81C : 32'h800, 1'b0);

    // Asynchronous reset while asleep.
    @(negedge clk);
    bus.valid_in = 1'b1; bus.wfi_in = 1'b1; bus.next_pc_in = 32'h300;
    repeat (3) @(negedge clk);
    clear_inputs();
    #1;
    check("rsleep_pre", bus.sleeping, 1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("rsleep");
    $display("txn reset_in_sleep: sleeping=%0b flush=%0b", bus.sleeping, bus.flush);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    check("rsleep_run_sleep", bus.sleeping, 0);
    check("rsleep_run_flush", bus.flush, 0);
    @(negedge clk);
    bus.mtvec_in = 32'h800;
    bus.valid_in = 1'b1; bus.exception_in = 1'b1; bus.ecause_in = 4'd4; bus.pc_in = 32'h500;
    #1;
    check("post_rst_trap", bus.trap_commit, 1);
    check("post_rst_epc", bus.trap_epc, 32'h500);
    drain_and_redirect("post_rst", 32'h800, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
